// File: rtl/kout_trace_capture_pkg.sv
// Shared types for the trace capture block: event kinds, record header layout
// and FSM state encoding.
package kout_trace_capture_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned HDR_W  = 2 + 3 * DATA_W;

  typedef enum logic [1:0] {
    KIND_CHANGE = 2'b00,
    KIND_START  = 2'b01,
    KIND_DONE   = 2'b10
  } kind_t;

  // Record = {header, ts}; the timestamp is appended by the top so its width can follow TS_W.
  typedef struct packed {
    kind_t             kind;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
  } rec_hdr_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/kout_trace_capture_trace_fifo.sv
// Register FIFO with a registered head word; push while full succeeds only
// when a pop happens on the same edge. No bypass from push to head.
module kout_trace_capture_trace_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 42
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             full_q, valid_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && valid_q;
  assign do_push = push_i && (!full_q || do_pop);

  // Next pointers, occupancy and head word.
  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    head_d = head_q;
    cnt_d  = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_pop)  rd_d = rd_q + PTR_W'(1);
    if (do_push) wr_d = wr_q + PTR_W'(1);
    // The pushed word becomes head only when it is the sole survivor of this edge.
    if (do_push && (cnt_q - CNT_W'(do_pop)) == '0) begin
      head_d = wdata_i;
    end else if (do_pop && cnt_d != '0) begin
      head_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      full_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      full_q  <= (cnt_d == CNT_W'(DEPTH));
      valid_q <= (cnt_d != '0);
    end
  end

  assign full_o  = full_q;
  assign valid_o = valid_q;
  assign count_o = cnt_q;
  assign head_o  = head_q;

endmodule

// File: rtl/kout_trace_capture.sv
// Observes a/b/c/d from the generated top, timestamps START/CHANGE/DONE events
// and streams them out through a small FIFO over valid/ready.
module kout_trace_capture
  import kout_trace_capture_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TS_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             a,
  input  logic [7:0]             b,
  input  logic [7:0]             c,
  input  logic                   d,
  input  logic                   en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_kind,
  output logic [7:0]             out_a,
  output logic [7:0]             out_b,
  output logic [7:0]             out_c,
  output logic [TS_W-1:0]        out_ts,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int unsigned REC_W = HDR_W + TS_W;

  state_t           state_q, state_d;
  logic [7:0]       prev_a_q, prev_b_q, prev_c_q;
  logic             prev_d_q;
  logic [TS_W-1:0]  ts_q;
  logic             overflow_q;

  logic             ev_valid;
  kind_t            ev_kind;
  logic             push, pop, fifo_full, drop;
  rec_hdr_t         wr_hdr, head_hdr;
  logic [REC_W-1:0] wr_rec, head_rec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Event detection; DONE and START absorb any same-cycle data change.
  always_comb begin
    state_d  = state_q;
    ev_valid = 1'b0;
    ev_kind  = KIND_CHANGE;
    case (state_q)
      ST_IDLE: begin
        if (d && !prev_d_q) begin
          ev_valid = 1'b1;
          ev_kind  = KIND_START;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!d) begin
          ev_valid = 1'b1;
          ev_kind  = KIND_DONE;
          state_d  = ST_IDLE;
        end else if (a != prev_a_q || b != prev_b_q || c != prev_c_q) begin
          ev_valid = 1'b1;
          ev_kind  = KIND_CHANGE;
        end
      end
    endcase
  end

  assign push   = ev_valid && en;
  assign pop    = out_valid && out_ready;
  assign drop   = push && fifo_full && !pop;
  assign wr_hdr = '{kind: ev_kind, a: a, b: b, c: c};
  assign wr_rec = {wr_hdr, ts_q};

  // History, timestamp and sticky overflow run independently of en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_a_q   <= '0;
      prev_b_q   <= '0;
      prev_c_q   <= '0;
      prev_d_q   <= 1'b0;
      ts_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      prev_a_q   <= a;
      prev_b_q   <= b;
      prev_c_q   <= c;
      prev_d_q   <= d;
      ts_q       <= ts_q + TS_W'(1);
      overflow_q <= overflow_q | drop;
    end
  end

  kout_trace_capture_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .wdata_i (wr_rec),
    .pop_i   (out_ready),
    .full_o  (fifo_full),
    .valid_o (out_valid),
    .count_o (count),
    .head_o  (head_rec)
  );

  assign head_hdr = head_rec[REC_W-1 -: HDR_W];
  assign out_kind = head_hdr.kind;
  assign out_a    = head_hdr.a;
  assign out_b    = head_hdr.b;
  assign out_c    = head_hdr.c;
  assign out_ts   = head_rec[TS_W-1:0];
  assign overflow = overflow_q;

endmodule

// File: tb/tb_kout_trace_capture.sv
// Self-checking bench: directed tables and sequences plus randomized traffic
// compared every cycle against a queue-based model of the event stream.
module tb_kout_trace_capture;

  localparam int DEPTH = 8;
  localparam int K_CHANGE = 0;
  localparam int K_START  = 1;
  localparam int K_DONE   = 2;

  logic       clk, rst;
  logic [7:0] a, b, c;
  logic       d, en, out_ready, rdy4;

  logic        out_valid, overflow;
  logic [1:0]  out_kind;
  logic [7:0]  out_a, out_b, out_c;
  logic [15:0] out_ts;
  logic [3:0]  count;

  logic        valid4, overflow4;
  logic [1:0]  kind4;
  logic [7:0]  a4, b4, c4;
  logic [3:0]  ts4;
  logic [3:0]  count4;

  kout_trace_capture #(.DEPTH(DEPTH), .TS_W(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .en(en),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_ts(out_ts),
    .count(count), .overflow(overflow)
  );

  kout_trace_capture #(.DEPTH(DEPTH), .TS_W(4)) dut4 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .en(en),
    .out_valid(valid4), .out_ready(rdy4), .out_kind(kind4),
    .out_a(a4), .out_b(b4), .out_c(c4), .out_ts(ts4),
    .count(count4), .overflow(overflow4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int kind;
    int a;
    int b;
    int c;
    int ts;
  } rec_t;

  typedef struct {
    int at;
    int ia;
    int ib;
    int ic;
    int id;
    rec_t exp;
  } vec_t;

  int   n_err = 0;
  int   n_chk = 0;
  rec_t mq[$];
  rec_t cap[$];
  bit   m_run, m_ovf, p_d;
  int   p_a, p_b, p_c, m_ts;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_out_kind", 32'(out_kind), 0);
    chk("rst_out_a", 32'(out_a), 0);
    chk("rst_out_ts", 32'(out_ts), 0);
    chk("rst_ts_counter", 32'(dut.ts_q), 0);
    chk("rst_count_ts4", 32'(count4), 0);
    m_run = 0; m_ovf = 0; p_d = 0;
    p_a = 0; p_b = 0; p_c = 0; m_ts = 0;
    mq.delete();
    cap.delete();
    rst = 1'b1;
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cyc(input int ia, input int ib, input int ic,
                     input bit id, input bit ien, input bit irdy);
    int   ev;
    rec_t r;
    a = 8'(ia); b = 8'(ib); c = 8'(ic);
    d = id; en = ien; out_ready = irdy;
    if (out_valid && irdy) begin
      r = '{int'(out_kind), int'(out_a), int'(out_b), int'(out_c), int'(out_ts)};
      cap.push_back(r);
    end
    ev = -1;
    if (m_run && !id) begin
      ev = K_DONE; m_run = 0;
    end else if (!m_run && id && !p_d) begin
      ev = K_START; m_run = 1;
    end else if (m_run && (ia != p_a || ib != p_b || ic != p_c)) begin
      ev = K_CHANGE;
    end
    if (mq.size() > 0 && irdy) void'(mq.pop_front());
    if (ev >= 0 && ien) begin
      if (mq.size() < DEPTH) begin
        r = '{ev, ia, ib, ic, m_ts};
        mq.push_back(r);
      end else begin
        m_ovf = 1;
      end
    end
    p_a = ia; p_b = ib; p_c = ic; p_d = id;
    m_ts = (m_ts + 1) % 65536;
    @(posedge clk);
    #1;
    chk("count", 32'(count), 32'(mq.size()));
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (mq.size() > 0) begin
      chk("head_kind", 32'(out_kind), 32'(mq[0].kind));
      chk("head_a", 32'(out_a), 32'(mq[0].a));
      chk("head_b", 32'(out_b), 32'(mq[0].b));
      chk("head_c", 32'(out_c), 32'(mq[0].c));
      chk("head_ts", 32'(out_ts), 32'(mq[0].ts));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[3];
    int   ia, ib, ic, id, thr;
    bit   dd;

    rst = 1'b0; a = '0; b = '0; c = '0; d = 1'b0; en = 1'b1;
    out_ready = 1'b0; rdy4 = 1'b0;
    #6;

    // Basic run: each entry is an input change at an edge and the record it must yield.
    tbl[0] = '{3,  0,  0, 0, 1, '{K_START,  0,  0, 0, 3}};
    tbl[1] = '{10, 48, 0, 0, 1, '{K_CHANGE, 48, 0, 0, 10}};
    tbl[2] = '{20, 48, 1, 0, 0, '{K_DONE,   48, 1, 0, 20}};
    do_reset();
    for (int i = 0; i < 25; i++) begin
      ia = 0; ib = 0; ic = 0; id = 0;
      foreach (tbl[k]) if (tbl[k].at <= i) begin
        ia = tbl[k].ia; ib = tbl[k].ib; ic = tbl[k].ic; id = tbl[k].id;
      end
      cyc(ia, ib, ic, id[0], 1'b1, 1'b1);
    end
    chk("basic_nrec", 32'(cap.size()), 3);
    foreach (tbl[k]) if (k < cap.size()) begin
      chk("basic_kind", 32'(cap[k].kind), 32'(tbl[k].exp.kind));
      chk("basic_a", 32'(cap[k].a), 32'(tbl[k].exp.a));
      chk("basic_b", 32'(cap[k].b), 32'(tbl[k].exp.b));
      chk("basic_c", 32'(cap[k].c), 32'(tbl[k].exp.c));
      chk("basic_ts", 32'(cap[k].ts), 32'(tbl[k].exp.ts));
    end

    // Backpressure: 10 changes into a stalled FIFO.
    do_reset();
    cyc(0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 10; k++) cyc(k, 0, 0, 1, 1, 0);
    chk("bp_count", 32'(count), 8);
    chk("bp_overflow", 32'(overflow), 1);
    for (int k = 1; k <= 8; k++) begin
      chk("bp_order", 32'(out_a), 32'(k));
      cyc(10, 0, 0, 1, 1, 1);
    end
    chk("bp_drained", 32'(count), 0);

    // Full FIFO with push and pop on the same edge.
    do_reset();
    cyc(0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 8; k++) cyc(k, 0, 0, 1, 1, 0);
    chk("fp_full", 32'(count), 8);
    cyc(9, 0, 0, 1, 1, 1);
    chk("fp_count", 32'(count), 8);
    chk("fp_overflow", 32'(overflow), 0);
    for (int k = 2; k <= 9; k++) begin
      chk("fp_order", 32'(out_a), 32'(k));
      cyc(9, 0, 0, 1, 1, 1);
    end
    chk("fp_empty", 32'(out_valid), 0);

    // Enable gating: START and change while disabled are never recorded.
    do_reset();
    cyc(5, 0, 0, 0, 0, 0);
    cyc(6, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) cyc(6, 0, 0, 1, 1, 0);
    chk("gate_count", 32'(count), 0);
    cyc(6, 0, 0, 0, 1, 0);
    chk("gate_done_kind", 32'(out_kind), 32'(K_DONE));
    chk("gate_done_ts", 32'(out_ts), 5);

    // Asynchronous reset with records buffered.
    do_reset();
    cyc(0, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 1, 1, 0);
    cyc(2, 0, 0, 1, 1, 0);
    chk("ar_buffered", 32'(count), 3);
    do_reset();
    cyc(0, 0, 0, 1, 1, 0);
    chk("ar_start_kind", 32'(out_kind), 32'(K_START));
    chk("ar_start_ts", 32'(out_ts), 0);

    // Timestamp wrap on the 4-bit instance.
    do_reset();
    rdy4 = 1'b0;
    for (int i = 0; i <= 16; i++) cyc((i >= 16) ? 2 : (i >= 15) ? 1 : 0, 0, 0, 1, 1, 1);
    chk("wrap_valid", 32'(valid4), 1);
    chk("wrap_start_kind", 32'(kind4), 32'(K_START));
    chk("wrap_start_ts", 32'(ts4), 0);
    rdy4 = 1'b1;
    cyc(2, 0, 0, 1, 1, 1);
    chk("wrap_ts15", 32'(ts4), 15);
    chk("wrap_a1", 32'(a4), 1);
    cyc(2, 0, 0, 1, 1, 1);
    chk("wrap_ts0", 32'(ts4), 0);
    chk("wrap_a2", 32'(a4), 2);
    chk("wrap_kind", 32'(kind4), 32'(K_CHANGE));
    chk("wrap_bc", 32'({b4, c4}), 0);
    chk("wrap_overflow", 32'(overflow4), 0);
    rdy4 = 1'b0;

    // Randomized traffic with varying backpressure.
    do_reset();
    dd = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      thr = (i / 150) % 4;
      if ($urandom_range(0, 7) == 0) dd = ~dd;
      cyc($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1), dd,
          $urandom_range(0, 9) != 0, $urandom_range(0, 3) <= thr);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
